// File: rtl/lcd_fetch_ctrl.sv
// lcd_fetch_ctrl
//   Sequences LCD video fetches on the shared memory bus, one scanline at a time.
//   Per cell: attribute lo byte, attribute hi byte, then a font byte from one
//   of four font banks (lores0/lores1/hires0/hires1). Each cell is handed to the
//   line buffer over a valid/ready handshake.
//   Only video slots (clkcnt != 2) are used; slot 2 belongs to the Z80.
//   Optional feature macro: LCD_FETCH_BLANK_EN. When it is defined, a line
//   request with the LCD disabled runs a blank line without bus fetches.
module lcd_fetch_ctrl #(
    parameter int NCOL = 106
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic [1:0]  clkcnt,
    input  logic        lcdon,
    input  logic [12:0] pb0w,
    input  logic [9:0]  pb1w,
    input  logic [8:0]  pb2w,
    input  logic [10:0] pb3w,
    input  logic [10:0] sbrw,
    input  logic [7:0]  vid_cdo,
    input  logic        line_req,
    input  logic        frame_start,
    output logic [21:0] va,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_data,
    output logic [4:0]  pix_attr,
    output logic        pix_last,
    output logic        busy,
    output logic        line_done,
    output logic        frame_done,
    output logic        ovr
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ALO  = 3'd1;
    localparam logic [2:0] S_AHI  = 3'd2;
    localparam logic [2:0] S_FNT  = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;

    localparam logic [6:0] LAST_COL = 7'(NCOL - 1);

    logic [2:0]  state;
    logic [6:0]  col;
    logic [2:0]  row;
    logic [2:0]  scan;
    logic        fs_pend;
    logic        blank;
    logic [7:0]  attr_lo;
    logic [7:0]  attr_hi;
    logic [21:0] va_q;

    logic        video_slot;
    logic        fetching;
    logic        start_line;
    logic        start_blank;
    logic        accept;
    logic        last_col;
    logic        line_end;
    logic        fs_apply;
    logic        hrs;
    logic [9:0]  code10;
    logic [8:0]  code9;
    logic [21:0] attr_addr;
    logic [21:0] font_addr;
    logic [4:0]  attr_dec;

    assign video_slot = (clkcnt != 2'd2);
    assign busy       = (state != S_IDLE);
    assign fetching   = (state == S_ALO) || (state == S_AHI) || (state == S_FNT);
    assign accept     = (state == S_EMIT) && pix_ready;
    assign last_col   = (col == LAST_COL);
    assign line_end   = accept && last_col;
    assign fs_apply   = fs_pend || frame_start;

`ifdef LCD_FETCH_BLANK_EN
    assign start_line  = (state == S_IDLE) && line_req;
    assign start_blank = !lcdon;
`else
    assign start_line  = (state == S_IDLE) && line_req && lcdon;
    assign start_blank = 1'b0;
`endif

    // Attribute fields and font bank selection
    assign hrs    = attr_hi[5];
    assign code10 = {attr_hi[1:0], attr_lo};
    assign code9  = {attr_hi[0], attr_lo};

    always_comb begin
        font_addr = '0;
        if (hrs) begin
            if (code10 >= 10'h300)
                font_addr = {pb3w, attr_lo, scan};
            else
                font_addr = {pb2w, code10, scan};
        end else begin
            if (code9 >= 9'h1C0)
                font_addr = {pb0w, code9[5:0], scan};
            else
                font_addr = {pb1w, code9, scan};
        end
    end

    // Hires cells carry no rev/flash/grey/ul
    assign attr_dec  = hrs ? 5'b10000 : {1'b0, attr_hi[4:1]};
    assign attr_addr = {sbrw, row, col, (state == S_AHI)};

    // Video address: live during fetches, otherwise the last fetch address
    always_comb begin
        va = va_q;
        if (state == S_FNT)
            va = font_addr;
        else if (fetching)
            va = attr_addr;
    end

    assign pix_valid = (state == S_EMIT);
    assign pix_last  = (state == S_EMIT) && last_col;

    // Fetch sequencer and column counter
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            state <= S_IDLE;
            col   <= '0;
            blank <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_line) begin
                        col   <= '0;
                        blank <= start_blank;
                        state <= start_blank ? S_EMIT : S_ALO;
                    end
                end
                S_ALO:  if (video_slot) state <= S_AHI;
                S_AHI:  if (video_slot) state <= S_FNT;
                S_FNT:  if (video_slot) state <= S_EMIT;
                S_EMIT: begin
                    if (pix_ready) begin
                        if (last_col) begin
                            state <= S_IDLE;
                        end else begin
                            col   <= col + 7'd1;
                            state <= blank ? S_EMIT : S_ALO;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus data capture at the edge ending each video slot
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            attr_lo  <= '0;
            attr_hi  <= '0;
            pix_data <= '0;
            pix_attr <= '0;
        end else begin
            if (start_line && start_blank) begin
                pix_data <= '0;
                pix_attr <= '0;
            end
            if (video_slot) begin
                if (state == S_ALO) attr_lo <= vid_cdo;
                if (state == S_AHI) attr_hi <= vid_cdo;
                if (state == S_FNT) begin
                    pix_data <= vid_cdo;
                    pix_attr <= attr_dec;
                end
            end
        end
    end

    // Hold register for the address shown in IDLE/EMIT
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n)
            va_q <= '0;
        else if (fetching)
            va_q <= va;
    end

    // Row/scan counters, pending frame restart and status pulses.
    // A frame_start seen on the final accept edge counts as pending.
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            row        <= '0;
            scan       <= '0;
            fs_pend    <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            line_done  <= line_end;
            frame_done <= line_end && !fs_apply && (row == 3'd7) && (scan == 3'd7);
            ovr        <= line_req && busy;
            if (state == S_IDLE) begin
                fs_pend <= 1'b0;
                if (frame_start) begin
                    row  <= '0;
                    scan <= '0;
                end
            end else if (line_end) begin
                fs_pend <= 1'b0;
                if (fs_apply) begin
                    row  <= '0;
                    scan <= '0;
                end else begin
                    scan <= scan + 3'd1;
                    if (scan == 3'd7)
                        row <= row + 3'd1;
                end
            end else if (frame_start) begin
                fs_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_fetch_ctrl.sv
// tb_lcd_fetch_ctrl
//   Randomized bench for lcd_fetch_ctrl with a memory model and a cell-level
//   reference model (addresses and attributes computed arithmetically).
//   Honours LCD_FETCH_BLANK_EN for the lcdon = 0 behaviour.
module tb_lcd_fetch_ctrl;

    localparam int NCOL = 4;

    logic        mck = 1'b0;
    logic        rin_n;
    logic [1:0]  clkcnt;
    logic        lcdon;
    logic [12:0] pb0w;
    logic [9:0]  pb1w;
    logic [8:0]  pb2w;
    logic [10:0] pb3w;
    logic [10:0] sbrw;
    logic [7:0]  vid_cdo;
    logic        line_req;
    logic        frame_start;
    logic [21:0] va;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic [4:0]  pix_attr;
    logic        pix_last;
    logic        busy;
    logic        line_done;
    logic        frame_done;
    logic        ovr;

    always #5 mck = ~mck;

    lcd_fetch_ctrl #(.NCOL(NCOL)) dut (
        .mck(mck), .rin_n(rin_n), .clkcnt(clkcnt), .lcdon(lcdon),
        .pb0w(pb0w), .pb1w(pb1w), .pb2w(pb2w), .pb3w(pb3w), .sbrw(sbrw),
        .vid_cdo(vid_cdo), .line_req(line_req), .frame_start(frame_start),
        .va(va), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_attr(pix_attr), .pix_last(pix_last),
        .busy(busy), .line_done(line_done), .frame_done(frame_done), .ovr(ovr)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state
    int   m_row = 0;
    int   m_scan = 0;
    bit   m_fs_pend = 0;
    bit   all_video = 0;
    int   fd_count = 0;
    bit   last_fd = 0;

    // Memory model: hashed contents plus a few pinned bytes
    logic [7:0]  salt = 8'h00;
    logic [21:0] ov_a [8];
    logic [7:0]  ov_d [8];
    int          ov_n = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [21:0] a);
        for (int i = 0; i < ov_n; i++)
            if (ov_a[i] == a) return ov_d[i];
        return 8'(a ^ (a >> 8) ^ (a >> 14)) ^ salt;
    endfunction

    task automatic pin_byte(input int a, input logic [7:0] d);
        ov_a[ov_n] = 22'(a);
        ov_d[ov_n] = d;
        ov_n++;
    endtask

    // One clock: outputs settled, choose this cycle's slot and bus data
    task automatic step();
        int v;
        @(posedge mck);
        #1;
        if (all_video) begin
            v = $urandom % 3;
            clkcnt = (v == 2) ? 2'd3 : 2'(v);
        end else begin
            clkcnt = 2'($urandom % 4);
        end
        vid_cdo = (clkcnt == 2'd2) ? 8'($urandom) : mem_rd(va);
    endtask

    // Expected cell contents for column c of the current scanline
    task automatic exp_cell(input int c, input bit blk, output logic [7:0] d,
                            output logic [4:0] at, output logic [21:0] fa);
        int a_lo, lo, hi, code;
        a_lo = int'(sbrw) * 2048 + m_row * 256 + c * 2;
        lo = int'(mem_rd(22'(a_lo)));
        hi = int'(mem_rd(22'(a_lo + 1)));
        if ((hi & 32) != 0) begin
            code = (hi & 3) * 256 + lo;
            at = 5'd16;
            if (code >= 'h300) fa = 22'(int'(pb3w) * 2048 + lo * 8 + m_scan);
            else               fa = 22'(int'(pb2w) * 8192 + code * 8 + m_scan);
        end else begin
            code = (hi & 1) * 256 + lo;
            at = 5'((hi >> 1) & 15);
            if (code >= 'h1C0) fa = 22'(int'(pb0w) * 512 + (code % 64) * 8 + m_scan);
            else               fa = 22'(int'(pb1w) * 4096 + code * 8 + m_scan);
        end
        d = mem_rd(fa);
        if (blk) begin
            d = 8'h00;
            at = 5'd0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_va"}, va, 0);
        check_eq({tag, "_valid"}, pix_valid, 0);
        check_eq({tag, "_data"}, pix_data, 0);
        check_eq({tag, "_attr"}, pix_attr, 0);
        check_eq({tag, "_last"}, pix_last, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_ldone"}, line_done, 0);
        check_eq({tag, "_fdone"}, frame_done, 0);
        check_eq({tag, "_ovr"}, ovr, 0);
    endtask

    task automatic randomize_cfg();
        pb0w = 13'($urandom);
        pb1w = 10'($urandom);
        pb2w = 9'($urandom);
        pb3w = 11'($urandom);
        sbrw = 11'($urandom);
        salt = 8'($urandom);
    endtask

    // Runs one scanline from IDLE and checks every cycle against the model
    task automatic run_line(input bit blk, input int stall_first, input bit inj_req,
                            input bit inj_fs, input bit fs_with_req);
        int c, vcount, inj_at, stall_left;
        bit prev_req, acc_last, was_valid, exp_fd;
        logic [7:0]  e_data;
        logic [4:0]  e_attr;
        logic [21:0] e_va;
        c = 0; vcount = 0; prev_req = 0; acc_last = 0; was_valid = 0;
        stall_left = stall_first;
        inj_at = $urandom_range(1, 3 * NCOL);
        lcdon = !blk;
        pix_ready = 1'b0;
        line_req = 1'b1;
        if (fs_with_req) begin
            frame_start = 1'b1;
            m_row = 0;
            m_scan = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            line_req = 1'b0;
            frame_start = 1'b0;
            if (acc_last) break;
            check_eq("ovr", ovr, prev_req);
            prev_req = 0;
            check_eq("line_done_early", line_done, 0);
            check_eq("busy", busy, 1);
            if (pix_valid) begin
                if (!was_valid) check_eq("fetch_slots", vcount, blk ? 0 : 3);
                was_valid = 1;
                exp_cell(c, blk, e_data, e_attr, e_va);
                check_eq("pix_data", pix_data, e_data);
                check_eq("pix_attr", pix_attr, e_attr);
                check_eq("pix_last", pix_last, (c == NCOL - 1));
                if (!blk) check_eq("va_emit", va, e_va);
                if (stall_left > 0) begin
                    pix_ready = 1'b0;
                    stall_left--;
                end else begin
                    pix_ready = ($urandom % 3) != 0;
                end
                if (pix_ready) begin
                    vcount = 0;
                    was_valid = 0;
                    if (c == NCOL - 1) acc_last = 1;
                    else c++;
                end
            end else begin
                pix_ready = 1'($urandom);
                if (clkcnt != 2'd2) vcount++;
            end
            if (inj_req && cyc == inj_at) begin
                line_req = 1'b1;
                prev_req = 1;
            end
            if (inj_fs && cyc == inj_at) begin
                frame_start = 1'b1;
                m_fs_pend = 1;
            end
            if (!blk && cyc == 2 && ($urandom % 2) == 1) lcdon = 1'b0;
        end
        check_eq("line_complete", acc_last, 1);
        check_eq("line_done", line_done, 1);
        check_eq("ovr_end", ovr, prev_req);
        check_eq("busy_end", busy, 0);
        if (m_fs_pend) begin
            m_row = 0;
            m_scan = 0;
            m_fs_pend = 0;
            exp_fd = 0;
        end else begin
            exp_fd = (m_row == 7) && (m_scan == 7);
            m_scan++;
            if (m_scan == 8) begin
                m_scan = 0;
                m_row = (m_row + 1) % 8;
            end
        end
        check_eq("frame_done", frame_done, exp_fd);
        if (frame_done) fd_count++;
        last_fd = frame_done;
        pix_ready = 1'b0;
        lcdon = 1'b1;
        step();
        check_eq("line_done_pulse", line_done, 0);
    endtask

    initial begin
        rin_n = 1'b0;
        clkcnt = 2'd0;
        lcdon = 1'b1;
        line_req = 1'b0;
        frame_start = 1'b0;
        pix_ready = 1'b0;
        vid_cdo = 8'h00;
        pb0w = '0; pb1w = '0; pb2w = '0; pb3w = '0; sbrw = '0;
        repeat (3) step();
        check_all_zero("reset");
        rin_n = 1'b1;
        step();

        // Lores1 cell at row 0 col 0 with pinned attribute/font bytes
        all_video = 1;
        sbrw = 11'h001;
        pb1w = 10'h001;
        pin_byte('h000800, 8'h41);
        pin_byte('h000801, 8'h00);
        pin_byte('h001208, 8'h5A);
        run_line(0, 0, 0, 0, 0);

        // Hires0 then hires1 cells
        pb3w = 11'h7FF;
        pb2w = 9'h0A5;
        pin_byte(int'(sbrw) * 2048 + m_row * 256 + 0, 8'h05);
        pin_byte(int'(sbrw) * 2048 + m_row * 256 + 1, 8'h20);
        pin_byte(int'(sbrw) * 2048 + m_row * 256 + 2, 8'h10);
        pin_byte(int'(sbrw) * 2048 + m_row * 256 + 3, 8'h23);
        run_line(0, 0, 0, 0, 0);

        // Long stall on the first cell, random slot pattern
        all_video = 0;
        ov_n = 0;
        randomize_cfg();
        run_line(0, 20, 0, 0, 0);

        // Full frame: 64 lines from row 0 / scan 0
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        m_row = 0;
        m_scan = 0;
        fd_count = 0;
        for (int n = 0; n < 64; n++) begin
            randomize_cfg();
            run_line(0, 0, 0, 0, 0);
        end
        check_eq("frames_in_64", fd_count, 1);
        check_eq("frame_on_64th", last_fd, 1);

        // Overrun and mid-line frame restart
        run_line(0, 0, 1, 0, 0);
        run_line(0, 0, 0, 1, 0);
        run_line(0, 0, 0, 0, 0);
        run_line(0, 0, 0, 0, 1);

        // Line request with the LCD disabled
`ifdef LCD_FETCH_BLANK_EN
        run_line(1, 3, 0, 0, 0);
`else
        lcdon = 1'b0;
        line_req = 1'b1;
        step();
        line_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq("lcdoff_busy", busy, 0);
            check_eq("lcdoff_ldone", line_done, 0);
            check_eq("lcdoff_ovr", ovr, 0);
            step();
        end
        lcdon = 1'b1;
`endif
        run_line(0, 0, 0, 0, 0);

        // Asynchronous reset while in the font fetch
        all_video = 1;
        sbrw = 11'h7FF;
        line_req = 1'b1;
        step();
        line_req = 1'b0;
        step();
        step();
        #2;
        rin_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_row = 0;
        m_scan = 0;
        m_fs_pend = 0;
        step();
        step();
        rin_n = 1'b1;
        step();
        run_line(0, 0, 0, 0, 0);

        // Random lines
        all_video = 0;
        for (int n = 0; n < 30; n++) begin
            randomize_cfg();
            run_line(0, ($urandom % 4 == 0) ? 5 : 0, 1'($urandom), 1'($urandom % 4 == 0),
                     1'($urandom % 5 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
